// File: rtl/uart_pkg.sv
// UART shared definitions: frame line levels, default width and FSM states.
// Common to the transmitter and the receiver so both agree on frame format.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// UART bit-period counter.
// Flags the final clock of every serial bit period.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || bit_end)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit.
// Host side is a valid/ready byte interface; tx_out idles high.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  par_en,
    input  logic                  par_odd,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    state_t                state;
    state_t                state_nx;
    logic                  bit_end;
    logic                  baud_clear;
    logic                  accept;
    logic                  last_data;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BW-1:0]         bit_cnt;
    logic                  par_q;
    logic                  par_en_q;

    assign accept     = tx_valid && tx_ready;
    assign last_data  = (bit_cnt == LAST_BIT);
    assign baud_clear = (state == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (baud_clear),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = START;
            START:   if (bit_end) state_nx = DATA;
            DATA:
                if (bit_end && last_data)
                    state_nx = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_nx = STOP;
            STOP:
                if (bit_end)
                    state_nx = accept ? START : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        tx_out   = IDLE_LEVEL;
        tx_busy  = 1'b1;
        tx_ready = 1'b0;
        tx_done  = 1'b0;
        unique case (state)
            IDLE: begin
                tx_busy  = 1'b0;
                tx_ready = 1'b1;
            end
            START:  tx_out = START_BIT;
            DATA:   tx_out = shift_q[0];
            PARITY: tx_out = par_q;
            STOP: begin
                tx_out   = STOP_BIT;
                tx_ready = bit_end;
                tx_done  = bit_end;
            end
            default: tx_out = IDLE_LEVEL;
        endcase
    end

    // Accept only happens in IDLE or the last STOP cycle, never while shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '0;
            bit_cnt  <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            if (accept) begin
                shift_q  <= tx_data_in;
                par_en_q <= par_en;
                par_q    <= (^tx_data_in) ^ par_odd;
            end else if (state == DATA && bit_end) begin
                shift_q <= shift_q >> 1;
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (state == START)
                bit_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one instance at 1 clock/bit, one at 4 clocks/bit.
// Frames are predicted on acceptance and checked cycle by cycle on tx_out.
module tb_uart_tx;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       par;
        int         acc_n;
    } exp_t;

    typedef struct {
        int         k;
        logic [7:0] d;
        logic       pe;
        logic       po;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] tx_valid = 2'b11;
    logic [1:0] par_en = 2'b11;
    logic [1:0] par_odd = 2'b00;
    logic [7:0] tx_data [2];
    logic [1:0] tx_ready;
    logic [1:0] tx_out;
    logic [1:0] tx_busy;
    logic [1:0] tx_done;

    int   ncyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   in_frame [2] = '{1'b0, 1'b0};
    int   ndone [2] = '{0, 0};
    int   aborts [2] = '{0, 0};
    exp_t sb [2][$];
    int   starts [2][$];

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .tx_data_in(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .par_en(par_en[0]),
        .par_odd(par_odd[0]), .tx_out(tx_out[0]),
        .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
    );

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .tx_data_in(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .par_en(par_en[1]),
        .par_odd(par_odd[1]), .tx_out(tx_out[1]),
        .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
    );

    initial begin
        forever begin
            #5 clk = 1'b1;
            #5;
            ncyc++;
            clk = 1'b0;
        end
    end

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h, expected %0h",
                     nm, $time, act, exp);
        end
    endfunction

    always @(negedge clk) if (tx_done[0] === 1'b1) ndone[0]++;
    always @(negedge clk) if (tx_done[1] === 1'b1) ndone[1]++;

    for (genvar g = 0; g < 2; g++) begin : g_mon
        initial begin
            exp_t       e;
            logic [10:0] bits;
            int         total;
            int         cpb;
            bit         have;
            bit         last;
            cpb = (g == 0) ? 1 : 4;
            forever begin
                @(negedge clk);
                if (!mon_en) continue;
                if (rst || tx_out[g] !== 1'b0) begin
                    chk("idle_out", tx_out[g], 1);
                    chk("idle_busy", tx_busy[g], 0);
                    chk("idle_done", tx_done[g], 0);
                    chk("idle_ready", tx_ready[g], 1);
                    continue;
                end
                have = (sb[g].size() != 0);
                chk("frame_expected", have, 1);
                if (!have) continue;
                e = sb[g].pop_front();
                in_frame[g] = 1'b1;
                chk("start_latency", ncyc, e.acc_n + 1);
                starts[g].push_back(ncyc);
                bits = '1;
                bits[0] = 1'b0;
                bits[8:1] = e.d;
                if (e.pe) bits[9] = e.par;
                total = (e.pe ? 11 : 10) * cpb;
                for (int i = 0; i < total; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst) begin
                        aborts[g]++;
                        chk("abort_out", tx_out[g], 1);
                        chk("abort_busy", tx_busy[g], 0);
                        chk("abort_done", tx_done[g], 0);
                        break;
                    end
                    last = (i == total - 1);
                    chk("tx_bit", tx_out[g], bits[i / cpb]);
                    chk("frame_busy", tx_busy[g], 1);
                    chk("frame_done", tx_done[g], last);
                    chk("frame_ready", tx_ready[g], last);
                end
                in_frame[g] = 1'b0;
            end
        end
    end

    task automatic send(input int k, input logic [7:0] d,
                        input logic pe, input logic po,
                        input logic par, input bit keep);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        @(negedge clk);
        #1;
        tx_data[k]  = d;
        par_en[k]   = pe;
        par_odd[k]  = po;
        tx_valid[k] = 1'b1;
        while (!ok && n < 400) begin
            if (tx_ready[k] === 1'b1) begin
                ok = 1'b1;
            end else begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        chk("accept_timeout", ok, 1);
        if (ok)
            sb[k].push_back('{d, pe, par, ncyc});
        if (!keep || !ok) begin
            @(negedge clk);
            #1;
            tx_valid[k] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((sb[k].size() != 0 || in_frame[k]) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("idle_timeout", n < 1000, 1);
    endtask

    vec_t vecs [10];
    int   d0;
    int   gap;

    initial begin
        vecs = '{
            '{0, 8'hC6, 1'b1, 1'b0, 1'b0},
            '{0, 8'h01, 1'b1, 1'b1, 1'b0},
            '{0, 8'h01, 1'b0, 1'b0, 1'b0},
            '{0, 8'hFF, 1'b1, 1'b0, 1'b0},
            '{0, 8'h07, 1'b1, 1'b0, 1'b1},
            '{0, 8'h80, 1'b1, 1'b1, 1'b0},
            '{0, 8'h00, 1'b1, 1'b1, 1'b1},
            '{1, 8'hC6, 1'b1, 1'b0, 1'b0},
            '{1, 8'h01, 1'b0, 1'b1, 1'b0},
            '{1, 8'h07, 1'b1, 1'b1, 1'b0}
        };
        tx_data[0] = 8'hFF;
        tx_data[1] = 8'hFF;

        // Reset held two cycles while a byte is offered.
        @(negedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out", tx_out[k], 1);
            chk("rst_busy", tx_busy[k], 0);
            chk("rst_done", tx_done[k], 0);
            chk("rst_ready", tx_ready[k], 1);
        end
        rst = 1'b0;
        tx_valid = 2'b00;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_no_frame", starts[0].size() + starts[1].size(), 0);

        for (int v = 0; v < 10; v++) begin
            d0 = ndone[vecs[v].k];
            send(vecs[v].k, vecs[v].d, vecs[v].pe, vecs[v].po,
                 vecs[v].par, 1'b0);
            wait_idle(vecs[v].k);
            chk("vec_done_pulse", ndone[vecs[v].k] - d0, 1);
        end

        // Back-to-back frames with tx_valid held high.
        d0 = ndone[0];
        send(0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        send(0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle(0);
        chk("b2b_done_pulses", ndone[0] - d0, 2);
        gap = starts[0][$] - starts[0][$-1];
        chk("b2b_start_gap", gap, 11);

        // Inputs disturbed while the frame is in DATA.
        d0 = ndone[1];
        send(1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        tx_data[1] = 8'hFF;
        par_odd[1] = 1'b1;
        par_en[1]  = 1'b0;
        wait_idle(1);
        chk("disturb_done", ndone[1] - d0, 1);

        // Reset in the middle of data bit 4 at 4 clocks per bit.
        d0 = ndone[1];
        send(1, 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_seen", aborts[1], 1);
        chk("abort_no_done", ndone[1] - d0, 0);
        send(1, 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle(1);
        chk("after_abort_done", ndone[1] - d0, 1);

        repeat (4) @(negedge clk);
        #1;
        chk("sb_empty0", sb[0].size(), 0);
        chk("sb_empty1", sb[1].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of the team's RX_top receiver.
- Serialises one byte per frame, LSB first: start bit (0), DATA_WIDTH data bits, optional parity bit, stop bit (1).
- Frame format and bit timing match what RX_top expects: one bit per CLKS_PER_BIT clocks, even parity by default.
- Sits between the host-side byte interface (valid/ready) and the serial line tx_out.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- CLKS_PER_BIT, 1, clocks each serial bit is held; must be >= 1.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- tx_data_in  input  DATA_WIDTH  byte to transmit.
- tx_valid  input  1  tx_data_in is valid.
- tx_ready  output  1  transmitter can accept a byte this cycle.
- par_en  input  1  1 = insert parity bit.
- par_odd  input  1  0 = even parity, 1 = odd parity.
- tx_out  output  1  serial line; idles high.
- tx_busy  output  1  a frame is in progress.
- tx_done  output  1  one-cycle pulse in the final cycle of the stop bit.

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - rst=1 at an edge forces state IDLE and clears all counters.
  - Reset values: tx_out=1, tx_busy=0, tx_done=0, tx_ready=1 in the cycle after reset.
- Reset mid-frame: the frame is aborted immediately; tx_out returns to 1 on the next edge and no tx_done is issued.
- Handshake:
  - A transfer occurs at an edge where tx_valid && tx_ready.
  - At that edge, tx_data_in, par_en and par_odd are latched into a shift register and config flops.
  - Parity is computed from the latched data: XOR of the data bits, XORed with par_odd.
  - Input changes after acceptance have no effect on the frame in flight.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out=1, tx_busy=0. On accept -> START.
  - START: tx_out=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx_out = shift_reg[0]; shift right at the end of each bit period. After DATA_WIDTH bits: -> PARITY if par_en, else -> STOP.
  - PARITY: tx_out = latched parity bit for CLKS_PER_BIT cycles -> STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles. tx_done=1 in the last cycle. Next state is START if a byte is accepted in that cycle, else IDLE.
- Latency: tx_out falls to 0 at the edge after acceptance.
- Frame length: (DATA_WIDTH + 2 + par_en) * CLKS_PER_BIT cycles.
- tx_ready = (state==IDLE) || (state==STOP && last baud cycle). This allows back-to-back frames with no idle gap.
- tx_busy = 1 in every state other than IDLE.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT), minimum 1 bit.
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary; last baud cycle = (count == CLKS_PER_BIT-1).
  - With CLKS_PER_BIT=1, every cycle is the last baud cycle.
- Bit counter: 0..DATA_WIDTH-1, cleared on entry to DATA.
- tx_valid while tx_ready=0 is ignored. The source must hold the byte until ready is seen.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - UART_DATA_WIDTH constant (8);
  - START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
  - RX_top is to be migrated onto the same package so both directions agree on frame format.
- Sub-module uart_baud_cnt:
  - parameter CLKS_PER_BIT;
  - inputs clk, rst, clear;
  - output bit_end, asserted in the last cycle of each bit period.
- FSM, shift register, parity and bit counter stay in uart_tx.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with tx_valid=1.
  - Required: tx_out=1, tx_busy=0, tx_done=0, tx_ready=1 after reset; no frame starts while rst=1.
- Basic frame, even parity (CLKS_PER_BIT=1, par_en=1, par_odd=0, byte 0xC6):
  - Required tx_out from the cycle after accept: 0, 0,1,1,0,0,0,1,1, 0, 1.
  - tx_done pulses with the stop bit; tx_busy is high for 11 cycles.
  - Looping tx_out into RX_top gives rx_data_out=0xC6 with no parity or stop errors.
- Odd parity, no parity, and timing:
  - Byte 0x01 with par_odd=1 -> parity bit 0.
  - Byte 0x01 with par_en=0 -> frame is 10 bits, stop bit directly after bit 7.
  - CLKS_PER_BIT=4: each bit is held exactly 4 cycles; frame is 44 cycles with parity.
- Back-to-back:
  - Stimulus: tx_valid held high with 0xA5 then 0x3C.
  - Required: second byte accepted in the last stop cycle of the first; its start bit follows the stop bit with no idle cycle; two tx_done pulses.
- Mid-frame disturbance:
  - Change tx_data_in and par_odd during the DATA state -> the frame in flight is unchanged.
  - Assert rst in the middle of bit 4 -> tx_out=1 next cycle, no tx_done, next accepted byte produces a clean frame.
